// File: rtl/seq_ceil_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_ceil_divider
// Description : Iterative unsigned divider that resolves one quotient bit per
//               clock using restoring division. Each request chooses either
//               the floor or the ceiling quotient. The floor remainder is
//               always returned. Requests enter and results leave through
//               valid/ready handshakes. This is the run-time equivalent of
//               the elaboration-time ceil_div constant function.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH          operand/result width, WIDTH >= 1
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     request valid
//   in_ready_o     request accepted when in_valid_i && in_ready_o
//   dividend_i     unsigned dividend
//   divisor_i      unsigned divisor
//   ceil_i         1 = ceiling quotient, 0 = floor quotient
//   out_valid_o    result valid
//   out_ready_i    result consumed when out_valid_o && out_ready_i
//   quotient_o     floor or ceiling quotient
//   remainder_o    floor remainder (dividend mod divisor)
//   div_by_zero_o  result came from a zero divisor
// ============================================================================
module seq_ceil_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             ceil_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    // The iteration counter must be able to hold WIDTH-1. It is never
    // narrower than one bit.
    localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_FIXUP = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_dbz;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ceil;
    logic [WIDTH-1:0]     r_divisor;
    // r_dq starts out holding the dividend. Each iteration shifts its MSB
    // into the partial remainder and shifts the new quotient bit in at the
    // LSB. After WIDTH iterations it holds the floor quotient.
    logic [WIDTH-1:0]     r_dq;
    // The partial remainder is always smaller than the divisor between
    // iterations, so WIDTH bits are enough to store it.
    logic [WIDTH-1:0]     r_rem;

    // ------------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------------
    logic [WIDTH:0]       w_rem_shift;
    logic [WIDTH:0]       w_divisor_ext;
    logic                 w_sub_ok;
    logic [WIDTH-1:0]     w_rem_diff;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_dq_next;
    logic                 w_round_up;
    logic [WIDTH-1:0]     w_quot_fix;

    // The shifted partial remainder needs WIDTH+1 bits. Its top bit can be
    // set only when the result is already at least as large as any divisor.
    assign w_rem_shift   = {r_rem, r_dq[WIDTH-1]};
    assign w_divisor_ext = {1'b0, r_divisor};
    assign w_sub_ok      = (w_rem_shift >= w_divisor_ext);

    // The true difference fits in WIDTH bits whenever w_sub_ok is set, so a
    // WIDTH-bit modular subtract of the low bits gives the exact result.
    assign w_rem_diff    = w_rem_shift[WIDTH-1:0] - r_divisor;
    assign w_rem_next    = w_sub_ok ? w_rem_diff : w_rem_shift[WIDTH-1:0];
    assign w_dq_next     = (r_dq << 1) | WIDTH'(w_sub_ok);

    // Ceiling rounding. ceil(x/d) <= 2^WIDTH-1 for every d >= 1, so adding
    // one to the floor quotient cannot wrap.
    assign w_round_up    = r_ceil && (r_rem != '0);
    assign w_quot_fix    = r_dq + WIDTH'(w_round_up);

    // ------------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_cnt       <= '0;
            r_ceil      <= 1'b0;
            r_divisor   <= '0;
            r_dq        <= '0;
            r_rem       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid_i) begin
                        r_ceil     <= ceil_i;
                        r_divisor  <= divisor_i;
                        r_dq       <= dividend_i;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (divisor_i == '0) begin
                            // A zero divisor skips the iterations. The
                            // result is known at once.
                            r_quotient  <= '1;
                            r_remainder <= dividend_i;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_state <= c_ST_BUSY;
                        end
                    end
                end

                c_ST_BUSY: begin
                    r_dq  <= w_dq_next;
                    r_rem <= w_rem_next;
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_FIXUP;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end

                c_ST_FIXUP: begin
                    r_quotient  <= w_quot_fix;
                    r_remainder <= r_rem;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_DONE;
                end

                c_ST_DONE: begin
                    // Return to IDLE only after the result handshake. The
                    // block does not accept a new request in that cycle.
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o    = r_in_ready;
    assign out_valid_o   = r_out_valid;
    assign quotient_o    = r_quotient;
    assign remainder_o   = r_remainder;
    assign div_by_zero_o = r_dbz;

    // ------------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
    a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=>
            (out_valid_o && $stable(quotient_o) && $stable(remainder_o)
             && $stable(div_by_zero_o)));

    a_hs_exclusive : assert property (@(posedge clk_i) disable iff (rst_i)
        !(in_ready_o && out_valid_o));
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_ceil_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_ceil_divider
// Description : Self-checking bench for seq_ceil_divider at WIDTH=8. Expected
//               results come from an independent floor/ceil model. They are
//               queued when a request is accepted and compared when the
//               result handshake happens.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_ceil_divider;

    localparam int W = 8;
    // Edges counted from the accept edge to the first visible out_valid.
    localparam int c_LAT_NORMAL = W + 1;
    localparam int c_LAT_DBZ    = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ceil_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_ceil_divider #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .ceil_i       (ceil_sel),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(dbz)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
        exp_t e;
        int   ia;
        int   ib;
        ia = int'(a);
        ib = int'(b);
        if (ib == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = c ? W'((ia + ib - 1) / ib) : W'(ia / ib);
            e.r = W'(ia % ib);
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: one comparison per result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got q=%0d r=%0d dbz=%0b, required no result",
                         quotient, remainder, dbz);
            end else begin
                e = sb.pop_front();
                if ({quotient, remainder, dbz} !== e) begin
                    n_fail++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                             quotient, remainder, dbz, e.q, e.r, e.z);
                end
            end
        end
    end

    // Call this at +1 after an edge. It returns at +1 after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit push);
        int guard;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        ceil_sel = c;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=%0b, required 1", in_ready);
        end
        if (push) sb.push_back(model(a, b, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        ceil_sel = 1'($urandom);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        dividend  = 8'd50;
        divisor   = 8'd3;
        ceil_sel  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_handshake: got in_ready=%0b out_valid=%0b, required 1/0",
                     in_ready, out_valid);
        end
        n_tests++;
        if ({quotient, remainder, dbz} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%0d r=%0d dbz=%0b, required 0/0/0",
                     quotient, remainder, dbz);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_basic;
        int edges;
        out_ready = 1'b1;
        send(8'd100, 8'd7, 1'b0, 1'b1);
        wait_valid(edges);
        n_tests++;
        if (edges != c_LAT_NORMAL || !out_valid) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, required %0d", edges, c_LAT_NORMAL);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_return_idle: got in_ready=%0b out_valid=%0b, required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_ceil_and_bounds;
        logic [W-1:0] ta [5] = '{8'd100, 8'd7,   8'd0, 8'd255, 8'd255};
        logic [W-1:0] tb [5] = '{8'd7,   8'd100, 8'd9, 8'd1,   8'd255};
        logic         tc [5] = '{1'b1,   1'b1,   1'b1, 1'b1,   1'b0};
        int edges;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(ta[i], tb[i], tc[i], 1'b1);
            wait_valid(edges);
            n_tests++;
            if (edges != c_LAT_NORMAL || !out_valid) begin
                n_fail++;
                $display("FAIL ceil_latency[%0d]: got %0d edges, required %0d",
                         i, edges, c_LAT_NORMAL);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero;
        int edges;
        out_ready = 1'b1;
        send(8'd5, 8'd0, 1'b1, 1'b1);
        wait_valid(edges);
        n_tests++;
        if (edges != c_LAT_DBZ || !out_valid) begin
            n_fail++;
            $display("FAIL dbz_latency: got %0d edges, required %0d", edges, c_LAT_DBZ);
        end
        @(posedge clk); #1;
        send(8'd6, 8'd3, 1'b0, 1'b1);
        wait_valid(edges);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int edges;
        out_ready = 1'b0;
        send(8'd100, 8'd7, 1'b0, 1'b1);
        wait_valid(edges);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({out_valid, in_ready, quotient, remainder, dbz} !== {1'b1, 1'b0, 8'd14, 8'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got v=%0b rdy=%0b q=%0d r=%0d dbz=%0b, required 1/0/14/2/0",
                         i, out_valid, in_ready, quotient, remainder, dbz);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_release: got in_ready=%0b out_valid=%0b, required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_mid_reset;
        int  edges;
        bit  seen;
        out_ready = 1'b1;
        send(8'd200, 8'd3, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got in_ready=%0b out_valid=%0b, required 1/0",
                     in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_reset_no_result: got out_valid=1, required 0");
        end
        send(8'd9, 8'd4, 1'b0, 1'b1);
        wait_valid(edges);
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int           edges;
        int           exp_lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 4));
                default: b = W'($urandom);
            endcase
            out_ready = 1'($urandom_range(0, 1));
            send(a, b, 1'($urandom), 1'b1);
            wait_valid(edges);
            exp_lat = (b == '0) ? c_LAT_DBZ : c_LAT_NORMAL;
            n_tests++;
            if (edges != exp_lat || !out_valid) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got %0d edges, required %0d",
                         i, edges, exp_lat);
            end
            if (!out_ready) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_ceil_and_bounds();
        test_div_zero();
        test_backpressure();
        test_mid_reset();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
